chromosome_eval_sequencer: RTL and testbench

Control stage directly upstream of the per-output error accumulator. It steps one chromosome evaluation through a programmable number of input sequences and holds each sequence for a programmable number of clock cycles. It drives the accumulator's processing, keep-result, cycle-counter and sequence-index inputs, plus the 8-bit stimulus applied to the chromosome. It pulses done when the accumulated sums are final and holds them until the next start.

---
 rtl/chromosome_eval_sequencer_if.sv | 55 +++++
 rtl/chromosome_eval_sequencer.sv | 173 +++++++++++++++++
 tb/tb_chromosome_eval_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chromosome_eval_sequencer_if.sv
// -----------------------------------------------------------------------------
// chromosome_eval_sequencer_if
//
// Purpose: bundles the control, configuration and status signals that pass
// between the chromosome evaluation sequencer and its controller.
//
// Signals (names seen from the sequencer):
//   iStart              begin an evaluation (taken in IDLE or HOLD only)
//   iAbort              abandon a running evaluation (CLEAR or RUN only)
//   iLastSequence       index of the final sequence, latched on leaving CLEAR
//   iCyclesPerSequence  cycles per sequence, latched on leaving CLEAR
//   iInputSequence      live stimulus table, entry k applied during sequence k
//   oProcessing         accumulator accumulate enable
//   oKeepResult         accumulator hold enable
//   oClockCycleCounter  cycle index within the current sequence
//   oCurrentSequence    current sequence index
//   oChromosomeInput    stimulus table entry for oCurrentSequence
//   oBusy               high in CLEAR and RUN
//   oDone               one-cycle pulse on entry to HOLD
//   oTotalCycles        RUN-cycle total (zero unless EVAL_TOTAL_CYCLES_EN)
//   oState              FSM state for debug: 0 IDLE, 1 CLEAR, 2 RUN, 3 HOLD
//
// Modports: master = controller / testbench, slave = sequencer.
// -----------------------------------------------------------------------------
interface chromosome_eval_sequencer_if #(
  parameter int SEQ_COUNT_W = 4
);
  logic                                  iStart;
  logic                                  iAbort;
  logic [SEQ_COUNT_W-1:0]                iLastSequence;
  logic [31:0]                           iCyclesPerSequence;
  logic [(2**SEQ_COUNT_W)-1:0][7:0]      iInputSequence;

  logic                                  oProcessing;
  logic                                  oKeepResult;
  logic [31:0]                           oClockCycleCounter;
  logic [SEQ_COUNT_W-1:0]                oCurrentSequence;
  logic [7:0]                            oChromosomeInput;
  logic                                  oBusy;
  logic                                  oDone;
  logic [31:0]                           oTotalCycles;
  logic [1:0]                            oState;

  modport master (
    output iStart, iAbort, iLastSequence, iCyclesPerSequence, iInputSequence,
    input  oProcessing, oKeepResult, oClockCycleCounter, oCurrentSequence,
           oChromosomeInput, oBusy, oDone, oTotalCycles, oState
  );

  modport slave (
    input  iStart, iAbort, iLastSequence, iCyclesPerSequence, iInputSequence,
    output oProcessing, oKeepResult, oClockCycleCounter, oCurrentSequence,
           oChromosomeInput, oBusy, oDone, oTotalCycles, oState
  );
endinterface

// File: rtl/chromosome_eval_sequencer.sv
// -----------------------------------------------------------------------------
// chromosome_eval_sequencer
//
// Purpose: steps one chromosome evaluation through (lastSeq+1) input
// sequences, holding each for cps clock cycles, and drives the downstream
// error accumulator (processing / keep / counter / sequence index) plus the
// 8-bit stimulus applied to the chromosome.
//
// Ports:
//   iClock  clock, all state on the rising edge
//   iReset  asynchronous active-high reset
//   bus     chromosome_eval_sequencer_if.slave (see interface header)
//
// Optional feature: define EVAL_TOTAL_CYCLES_EN to build the saturating
// RUN-cycle total on oTotalCycles; otherwise oTotalCycles is tied to zero.
//
// Handshake: iStart and iAbort are level-sampled commands, not valid/ready
// pairs. iStart is accepted only in IDLE or HOLD and acceptance is visible as
// oBusy=1 (state CLEAR) after that edge; it is ignored while oBusy is high.
// iAbort is honoured only while oBusy is high and beats a coincident iStart.
// -----------------------------------------------------------------------------
module chromosome_eval_sequencer #(
  parameter int SEQ_COUNT_W = 4,
  parameter int MIN_CYCLES  = 1
) (
  input  logic                            iClock,
  input  logic                            iReset,
  chromosome_eval_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] MIN_CPS = 32'(MIN_CYCLES);

  state_t                 state;
  logic [SEQ_COUNT_W-1:0] last_seq;
  logic [SEQ_COUNT_W-1:0] seq;
  logic [SEQ_COUNT_W-1:0] seq_inc;
  logic [31:0]            cps;
  logic [31:0]            counter;
  logic                   processing;
  logic                   keep;
  logic                   busy;
  logic                   done;
  logic [7:0]             chrom;

  assign seq_inc = seq + SEQ_COUNT_W'(1);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= IDLE;
      last_seq   <= '0;
      seq        <= '0;
      cps        <= MIN_CPS;
      counter    <= '0;
      processing <= 1'b0;
      keep       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      chrom      <= '0;
    end else begin
      done  <= 1'b0;
      // The table is read live; branches that change seq override this with
      // the entry of the new index so stimulus and index move together.
      chrom <= bus.iInputSequence[seq];
      unique case (state)
        IDLE: begin
          processing <= 1'b0;
          keep       <= 1'b0;
          busy       <= 1'b0;
          if (bus.iStart) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (bus.iAbort) begin
            state      <= IDLE;
            processing <= 1'b0;
            keep       <= 1'b0;
            busy       <= 1'b0;
            counter    <= '0;
            seq        <= '0;
            chrom      <= bus.iInputSequence[0];
          end else begin
            last_seq   <= bus.iLastSequence;
            cps        <= (bus.iCyclesPerSequence < MIN_CPS) ? MIN_CPS
                                                             : bus.iCyclesPerSequence;
            counter    <= '0;
            seq        <= '0;
            chrom      <= bus.iInputSequence[0];
            processing <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (bus.iAbort) begin
            state      <= IDLE;
            processing <= 1'b0;
            keep       <= 1'b0;
            busy       <= 1'b0;
            counter    <= '0;
            seq        <= '0;
            chrom      <= bus.iInputSequence[0];
          end else if (counter < cps - 32'd1) begin
            // cps is floored at MIN_CYCLES >= 1, so cps-1 cannot wrap.
            counter <= counter + 32'd1;
          end else if (seq < last_seq) begin
            counter <= '0;
            seq     <= seq_inc;
            chrom   <= bus.iInputSequence[seq_inc];
          end else begin
            // Counter and seq stay on their final values through HOLD.
            state      <= HOLD;
            processing <= 1'b0;
            keep       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.iStart) begin
            state <= CLEAR;
            keep  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EVAL_TOTAL_CYCLES_EN
  logic [31:0] total;

  // Counts completed RUN cycles; zero outside an evaluation, frozen in HOLD.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      total <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.iAbort)         total <= '0;
          else if (total != '1)   total <= total + 32'd1;
        end
        HOLD: begin
          if (bus.iStart)         total <= '0;
        end
        default:                  total <= '0;
      endcase
    end
  end

  assign bus.oTotalCycles = total;
`else
  assign bus.oTotalCycles = '0;
`endif

  assign bus.oProcessing        = processing;
  assign bus.oKeepResult        = keep;
  assign bus.oClockCycleCounter = counter;
  assign bus.oCurrentSequence   = seq;
  assign bus.oChromosomeInput   = chrom;
  assign bus.oBusy              = busy;
  assign bus.oDone              = done;
  assign bus.oState             = state;

endmodule

// File: tb/tb_chromosome_eval_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chromosome_eval_sequencer
//
// Self-checking bench for chromosome_eval_sequencer. A reference model builds
// the expected RUN trace ({sequence, counter} per cycle) from the evaluation
// parameters into exp_q and the bench compares the DUT cycle by cycle.
// -----------------------------------------------------------------------------
module tb_chromosome_eval_sequencer;

`ifdef EVAL_TOTAL_CYCLES_EN
  localparam bit TOTAL_EN = 1'b1;
`else
  localparam bit TOTAL_EN = 1'b0;
`endif

  localparam int MIN_CYCLES = 1;

  // state codes shown on the debug output
  localparam int ST_IDLE  = 0;
  localparam int ST_CLEAR = 1;
  localparam int ST_RUN   = 2;
  localparam int ST_HOLD  = 3;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [35:0] exp_q[$];

  chromosome_eval_sequencer_if #(.SEQ_COUNT_W(4)) bus ();

  chromosome_eval_sequencer #(
    .SEQ_COUNT_W (4),
    .MIN_CYCLES  (MIN_CYCLES)
  ) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_processing"}, bus.oProcessing, 0);
    check({tag, "_keep"}, bus.oKeepResult, 0);
    check({tag, "_counter"}, bus.oClockCycleCounter, 0);
    check({tag, "_seq"}, bus.oCurrentSequence, 0);
    check({tag, "_chrom"}, bus.oChromosomeInput, 0);
    check({tag, "_busy"}, bus.oBusy, 0);
    check({tag, "_done"}, bus.oDone, 0);
    check({tag, "_total"}, bus.oTotalCycles, 0);
    check({tag, "_state"}, bus.oState, ST_IDLE);
  endtask

  // One evaluation from IDLE or HOLD. abort_at >= 0 asserts iAbort (with
  // iStart) during that RUN cycle index. Ends in HOLD, or IDLE after abort.
  task automatic run_eval(input int last, input int cps, input int abort_at,
                          input bit fixed_tbl);
    logic [15:0][7:0] tbl;
    logic [35:0]      e;
    int               eff;
    int               k;
    eff = (cps < MIN_CYCLES) ? MIN_CYCLES : cps;

    // reference model: sequence-major walk over (seq, counter)
    exp_q.delete();
    for (int s = 0; s <= last; s++)
      for (int c = 0; c < eff; c++)
        exp_q.push_back({4'(s), 32'(c)});

    for (int i = 0; i < 16; i++)
      tbl[i] = fixed_tbl ? 8'(8'h10 + i) : 8'($urandom_range(0, 255));

    bus.iInputSequence     = tbl;
    bus.iLastSequence      = 4'(last);
    bus.iCyclesPerSequence = 32'(cps);
    bus.iStart             = 1'b1;
    step();
    bus.iStart = 1'b0;

    check("clear_state", bus.oState, ST_CLEAR);
    check("clear_busy", bus.oBusy, 1);
    check("clear_processing", bus.oProcessing, 0);
    check("clear_keep", bus.oKeepResult, 0);
    check("clear_done", bus.oDone, 0);
    check("clear_total", bus.oTotalCycles, 0);

    step();
    // settings are latched by now; scramble them to expose late latching
    bus.iLastSequence      = 4'($urandom_range(0, 15));
    bus.iCyclesPerSequence = 32'($urandom_range(0, 7));

    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("run_state", bus.oState, ST_RUN);
      check("run_processing", bus.oProcessing, 1);
      check("run_keep", bus.oKeepResult, 0);
      check("run_busy", bus.oBusy, 1);
      check("run_done", bus.oDone, 0);
      check("run_counter", bus.oClockCycleCounter, e[31:0]);
      check("run_seq", bus.oCurrentSequence, e[35:32]);
      check("run_chrom", bus.oChromosomeInput, tbl[e[35:32]]);
      check("run_total", bus.oTotalCycles, TOTAL_EN ? k : 0);
      if (k == abort_at) begin
        bus.iAbort = 1'b1;
        bus.iStart = 1'b1;
        step();
        bus.iAbort = 1'b0;
        bus.iStart = 1'b0;
        check("abort_state", bus.oState, ST_IDLE);
        check("abort_processing", bus.oProcessing, 0);
        check("abort_keep", bus.oKeepResult, 0);
        check("abort_busy", bus.oBusy, 0);
        check("abort_done", bus.oDone, 0);
        check("abort_total", bus.oTotalCycles, 0);
        for (int i = 0; i < 3; i++) begin
          step();
          check("abort_idle_state", bus.oState, ST_IDLE);
          check("abort_idle_done", bus.oDone, 0);
        end
        exp_q.delete();
        return;
      end
      step();
      k++;
    end

    check("hold_state", bus.oState, ST_HOLD);
    check("hold_done", bus.oDone, 1);
    check("hold_keep", bus.oKeepResult, 1);
    check("hold_processing", bus.oProcessing, 0);
    check("hold_busy", bus.oBusy, 0);
    check("hold_counter", bus.oClockCycleCounter, eff - 1);
    check("hold_seq", bus.oCurrentSequence, last);
    check("hold_total", bus.oTotalCycles, TOTAL_EN ? (last + 1) * eff : 0);

    // abort is ignored in HOLD, done does not repeat
    bus.iAbort = 1'b1;
    step();
    bus.iAbort = 1'b0;
    check("hold2_state", bus.oState, ST_HOLD);
    check("hold2_done", bus.oDone, 0);
    check("hold2_keep", bus.oKeepResult, 1);
    check("hold2_counter", bus.oClockCycleCounter, eff - 1);
    check("hold2_total", bus.oTotalCycles, TOTAL_EN ? (last + 1) * eff : 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int last;
    int cps;
    int ab;
    n_checks = 0;
    n_fail   = 0;

    bus.iStart             = 1'b0;
    bus.iAbort             = 1'b0;
    bus.iLastSequence      = '0;
    bus.iCyclesPerSequence = '0;
    bus.iInputSequence     = '0;

    rst = 1'b1;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_reset_state", bus.oState, ST_IDLE);
    check("post_reset_keep", bus.oKeepResult, 0);

    // abort in IDLE is ignored
    bus.iAbort = 1'b1;
    step();
    bus.iAbort = 1'b0;
    check("idle_abort_state", bus.oState, ST_IDLE);

    run_eval(1, 3, -1, 1'b0);      // basic: 2 sequences x 3 cycles
    run_eval(0, 0, -1, 1'b0);      // cps=0 floored to 1
    run_eval(15, 2, -1, 1'b1);     // full table, 32 RUN cycles
    run_eval(2, 3, 3, 1'b0);       // abort+start on 4th RUN cycle
    run_eval(1, 3, -1, 1'b0);
    run_eval(1, 5, -1, 1'b0);      // restart from HOLD with new cps

    // randomized evaluations, occasionally aborted
    for (int n = 0; n < 10; n++) begin
      last = $urandom_range(0, 15);
      cps  = $urandom_range(0, 4);
      ab   = -1;
      if ($urandom_range(0, 3) == 0)
        ab = $urandom_range(0, (last + 1) * ((cps < 1) ? 1 : cps) - 1);
      run_eval(last, cps, ab, 1'b0);
    end

    // asynchronous reset in the middle of RUN
    bus.iLastSequence      = 4'd3;
    bus.iCyclesPerSequence = 32'd4;
    bus.iInputSequence     = {16{8'hA5}};
    bus.iStart             = 1'b1;
    step();
    bus.iStart = 1'b0;
    step();
    step();
    step();
    check("pre_reset_state", bus.oState, ST_RUN);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("after_reset_state", bus.oState, ST_IDLE);
      check("after_reset_done", bus.oDone, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
